// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges an unstalled ALU port (A) and a
// FIFO-buffered valid/ready port (B) into one registered SRAM write port.
module regfile_wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_a_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_a_addr,
  input  logic [WIDTH-1:0]           i_a_data,
  input  logic                       i_b_valid,
  output logic                       o_b_ready,
  input  logic [$clog2(DEPTH)-1:0]   i_b_addr,
  input  logic [WIDTH-1:0]           i_b_data,
  output logic                       o_w_e,
  output logic [$clog2(DEPTH)-1:0]   o_w_addr,
  output logic [WIDTH-1:0]           o_w_data,
  input  logic [$clog2(DEPTH)-1:0]   i_q0_addr,
  output logic                       o_q0_busy,
  input  logic [$clog2(DEPTH)-1:0]   i_q1_addr,
  output logic                       o_q1_busy,
  output logic                       o_starve,
  output logic [$clog2(QDEPTH):0]    o_b_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    mem_addr [QDEPTH];
  logic [WIDTH-1:0] mem_data [QDEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [7:0]       starve_cnt, starve_nxt;
  logic             a_eff, b_store, fifo_empty, deq;
  logic [PW-1:0]    idx;

  assign o_b_count = count;

  always_comb begin
    a_eff      = i_a_valid && (i_a_addr != '0);
    fifo_empty = (count == '0);
    o_b_ready  = !i_rst && (count < CW'(QDEPTH));
    // Register-0 writes complete the handshake but never occupy a slot.
    b_store    = i_b_valid && o_b_ready && (i_b_addr != '0);
    deq        = !a_eff && !fifo_empty;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (fifo_empty || deq)
      starve_nxt = '0;
    else if (a_eff && (starve_cnt != 8'(STARVE_LIMIT)))
      starve_nxt = starve_cnt + 8'd1;
  end

  // Only occupied slots (rd_ptr .. rd_ptr+count-1) are searched.
  always_comb begin
    o_q0_busy = 1'b0;
    o_q1_busy = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < QDEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (mem_addr[idx] == i_q0_addr) o_q0_busy = 1'b1;
        if (mem_addr[idx] == i_q1_addr) o_q1_busy = 1'b1;
      end
    end
    if (i_q0_addr == '0) o_q0_busy = 1'b0;
    if (i_q1_addr == '0) o_q1_busy = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_w_e      <= 1'b0;
      o_w_addr   <= '0;
      o_w_data   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      o_starve   <= 1'b0;
    end else begin
      if (a_eff) begin
        o_w_e    <= 1'b1;
        o_w_addr <= i_a_addr;
        o_w_data <= i_a_data;
      end else if (deq) begin
        o_w_e    <= 1'b1;
        o_w_addr <= mem_addr[rd_ptr];
        o_w_data <= mem_data[rd_ptr];
      end else begin
        o_w_e    <= 1'b0;
      end

      if (b_store) begin
        mem_addr[wr_ptr] <= i_b_addr;
        mem_data[wr_ptr] <= i_b_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (deq)
        rd_ptr <= rd_ptr + PW'(1);

      case ({b_store, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      starve_cnt <= starve_nxt;
      o_starve   <= (starve_nxt == 8'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model
// predicts SRAM writes and per-cycle status; a monitor checks the write port.
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 32, DEPTH = 32, QDEPTH = 4, LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0, q0_addr = '0, q1_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        b_ready, w_e, q0_busy, q1_busy, starve;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [2:0]  b_count;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .QDEPTH(QDEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_w_e(w_e), .o_w_addr(w_addr), .o_w_data(w_data),
    .i_q0_addr(q0_addr), .o_q0_busy(q0_busy),
    .i_q1_addr(q1_addr), .o_q1_busy(q1_busy),
    .o_starve(starve), .o_b_count(b_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    bit          is_rst;
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  ent_t fq[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   sc = 0;
  int   tests = 0, fails = 0;
  bit   armed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endfunction

  function automatic bit in_fifo(input logic [4:0] a);
    if (a == 0) return 0;
    foreach (fq[i]) if (fq[i].addr == a) return 1;
    return 0;
  endfunction

  // Write-port monitor: pops the scoreboard whenever a write is due.
  initial begin
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    exp_t e;
    last_addr = '0;
    last_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          if (e.is_rst) begin
            check("rst_w_e", 64'(w_e), 64'd0);
            last_addr = '0;
            last_data = '0;
            check("rst_w_addr", 64'(w_addr), 64'd0);
            check("rst_w_data", 64'(w_data), 64'd0);
          end else begin
            check("w_e", 64'(w_e), 64'd1);
            check("w_addr", 64'(w_addr), 64'(e.addr));
            check("w_data", 64'(w_data), 64'(e.data));
            last_addr = e.addr;
            last_data = e.data;
          end
        end else begin
          check("idle_w_e", 64'(w_e), 64'd0);
          check("hold_w_addr", 64'(w_addr), 64'(last_addr));
          check("hold_w_data", 64'(w_data), 64'(last_data));
        end
      end
    end
  end

  // One cycle of stimulus: drive, check combinational status, advance model.
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] qa0, input logic [4:0] qa1);
    bit exp_ready, was_empty, dq, aeff;
    ent_t h;
    @(negedge clk);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; q0_addr = qa0; q1_addr = qa1;
    #1;
    exp_ready = !r && (fq.size() < QDEPTH);
    check("b_ready", 64'(b_ready), 64'(exp_ready));
    if (r) begin
      fq.delete();
      sc = 0;
      exp_q.push_back('{1'b1, 5'd0, 32'd0, cyc + 1});
      armed = 1;
      return;
    end
    if (!armed) return;
    check("b_count", 64'(b_count), 64'(fq.size()));
    check("starve", 64'(starve), 64'(sc >= LIMIT));
    check("q0_busy", 64'(q0_busy), 64'(in_fifo(qa0)));
    check("q1_busy", 64'(q1_busy), 64'(in_fifo(qa1)));
    aeff = av && (aa != 0);
    was_empty = (fq.size() == 0);
    dq = 0;
    if (aeff) begin
      exp_q.push_back('{1'b0, aa, ad, cyc + 1});
    end else if (!was_empty) begin
      h = fq.pop_front();
      exp_q.push_back('{1'b0, h.addr, h.data, cyc + 1});
      dq = 1;
    end
    if (was_empty || dq) sc = 0;
    else if (aeff && sc < LIMIT) sc++;
    if (bv && exp_ready && ba != 0) fq.push_back('{ba, bd});
  endtask

  task automatic idle(input int n, input logic [4:0] qa);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, qa, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with B requesting; ready must stay low.
    step(1, 0, 0, 0, 1, 5'd9, 32'h1111, 0, 0);
    step(1, 0, 0, 0, 1, 5'd9, 32'h1111, 0, 0);
    idle(2, 0);
    // A only, then an A write to register 0.
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0);
    idle(2, 0);
    // B burst 1..4 with A idle, watching register 3.
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1, 5'(i), 32'hB000 + i, 5'd3, 5'(i));
    idle(6, 5'd3);
    // Contention: B holds 7 while A writes 10, 11, 12.
    step(0, 1, 5'd10, 32'hA10, 1, 5'd7, 32'hB07, 5'd7, 5'd10);
    step(0, 1, 5'd11, 32'hA11, 0, 0, 0, 5'd7, 0);
    step(0, 1, 5'd12, 32'hA12, 0, 0, 0, 5'd7, 0);
    idle(3, 5'd7);
    // Starvation: B entry stuck behind 10 A cycles.
    step(0, 1, 5'd20, 32'hC0, 1, 5'd8, 32'hB08, 5'd8, 0);
    for (int i = 1; i < 10; i++) step(0, 1, 5'(20 + i), 32'hC0 + i, 0, 0, 0, 5'd8, 0);
    idle(3, 5'd8);
    // Fill FIFO under A traffic, then release A while B keeps pushing.
    for (int i = 0; i < 4; i++) step(0, 1, 5'd30, 32'hD0 + i, 1, 5'(12 + i), 32'hE0 + i, 5'd13, 5'd15);
    step(0, 0, 0, 0, 1, 5'd16, 32'hE4, 5'd16, 0);
    step(0, 1, 5'd31, 32'hD9, 1, 5'd16, 32'hE4, 5'd16, 0);
    step(0, 1, 5'd31, 32'hDA, 1, 5'd0, 32'hE5, 5'd16, 0);
    idle(8, 5'd16);
    // Randomized traffic with occasional mid-operation reset.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 45, 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(QDEPTH + 4, 0);
    check("drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
